n64_sample_i2s_tx: RTL

- Parallel-to-serial I2S transmitter for 16-bit stereo PCM.
- Runs in the audio MCLK domain and takes left/right sample pairs through a valid/ready handshake into a small FIFO.
- Generates SCLK, LRCLK and SDATA as master, in the same wire format the N64 audio capture path decodes:
  - LRCLK high = left, low = right.
  - 2's complement, MSB first.
  - Data sampled by the receiver on SCLK rising edge.
  - One-SCLK data delay after each LRCLK transition.
- Used to drive the external audio DAC/HDMI I2S input, and as loopback stimulus for the capture path.

---
 rtl/n64_sample_i2s_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/n64_sample_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module : n64_sample_i2s_tx
// Brief  : I2S master transmitter for 16-bit stereo PCM, fed through a small
//          sample-pair FIFO. LRCLK high = left, MSB first, one-SCLK data delay.
// Rev    : 1.0
// ============================================================================
module n64_sample_i2s_tx #(
  parameter int SCLK_HALF = 4,
  parameter int SLOT_BITS = 16,
  parameter int FIFO_AW   = 2
) (
  input  logic               MCLK_i,
  input  logic               RST_i,
  input  logic [15:0]        PDATA_LEFT_i,
  input  logic [15:0]        PDATA_RIGHT_i,
  input  logic               PDATA_VALID_i,
  output logic               PDATA_READY_o,
  output logic [FIFO_AW:0]   FIFO_LEVEL_o,
  output logic               UNDERRUN_o,
  output logic               SCLK_o,
  output logic               LRCLK_o,
  output logic               SDATA_o
);

  localparam int                 c_DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_FULL     = c_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   c_LVL_ONE  = 1;
  localparam logic [FIFO_AW-1:0] c_PTR_ONE  = 1;
  localparam logic [7:0]         c_DIV_LAST = 8'(SCLK_HALF - 1);
  localparam logic [6:0]         c_K_LAST   = 7'(2 * SLOT_BITS - 1);
  localparam logic [6:0]         c_SLOT     = 7'(SLOT_BITS);
  localparam logic [6:0]         c_R_TOP    = 7'(SLOT_BITS + 16);

  logic [31:0]        r_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_ready;
  logic               r_underrun;
  logic [7:0]         r_div;
  logic               r_sclk;
  logic [6:0]         r_k;
  logic               r_lrclk;
  logic               r_sdata;
  logic [15:0]        r_left, r_right;

  logic               w_fall, w_start, w_empty, w_push, w_pop, w_bit;
  logic [6:0]         w_k_next;
  logic [3:0]         w_lidx, w_ridx;
  logic [FIFO_AW:0]   w_level_next;

  assign w_fall   = r_sclk & (r_div == c_DIV_LAST);
  assign w_k_next = (r_k == c_K_LAST) ? 7'd0 : r_k + 7'd1;
  assign w_start  = w_fall & (w_k_next == 7'd0);
  assign w_empty  = (r_level == '0);
  assign w_push   = PDATA_VALID_i & r_ready;
  assign w_pop    = w_start & ~w_empty;

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)
      w_level_next = r_level + c_LVL_ONE;
    else if (!w_push && w_pop)
      w_level_next = r_level - c_LVL_ONE;
  end

  // Bit for the slot position about to start; at k=0 the frame register
  // still holds the previous pair, which supplies the trailing right LSB.
  always_comb begin
    w_bit  = 1'b0;
    w_lidx = 4'(7'd16 - w_k_next);
    w_ridx = 4'(c_R_TOP - w_k_next);
    if (w_k_next == 7'd0)
      w_bit = (SLOT_BITS == 16) ? r_right[0] : 1'b0;
    else if (w_k_next <= 7'd16)
      w_bit = r_left[w_lidx];
    else if (w_k_next > c_SLOT && w_k_next <= c_R_TOP)
      w_bit = r_right[w_ridx];
  end

  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_div      <= '0;
      r_sclk     <= 1'b0;
      r_k        <= c_K_LAST;  // first falling edge then lands on k=0
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
    end else begin
      r_level    <= w_level_next;
      r_ready    <= (w_level_next < c_FULL);
      r_underrun <= w_start & w_empty;
      if (w_push)
        r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop) begin
        r_rptr            <= r_rptr + c_PTR_ONE;
        {r_left, r_right} <= r_mem[r_rptr];
      end
      if (r_div == c_DIV_LAST) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div  <= r_div + 8'd1;
      end
      if (w_fall) begin
        r_k     <= w_k_next;
        r_lrclk <= (w_k_next < c_SLOT);
        r_sdata <= w_bit;
      end
    end
  end

  always_ff @(posedge MCLK_i) begin
    if (w_push)
      r_mem[r_wptr] <= {PDATA_LEFT_i, PDATA_RIGHT_i};
  end

  assign PDATA_READY_o = r_ready;
  assign FIFO_LEVEL_o  = r_level;
  assign UNDERRUN_o    = r_underrun;
  assign SCLK_o        = r_sclk;
  assign LRCLK_o       = r_lrclk;
  assign SDATA_o       = r_sdata;

endmodule
`default_nettype wire
